serial_subtractor_ctrl: RTL

Bit-serial WIDTH-bit subtractor controller. It sequences one full_subtractor cell over WIDTH clock cycles, LSB first, and holds the inter-bit borrow in a flip-flop. Operands enter and results leave through a valid/ready handshake, so the block trades throughput for area. It sits between an operand source and a result sink in the combinational-basics datapath.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// serial_subtractor_ctrl_pkg
// Shared definitions for the bit-serial subtractor controller:
//   state_t   - FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_bits  - width of the bit counter for a given operand width
package serial_subtractor_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter only has to reach width-1, so $clog2(width) bits suffice.
    // Widths below 2 are illegal, but the floor of 1 keeps the counter
    // declaration valid.
    function automatic int cnt_bits(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
// One-bit full subtractor cell: diff = a - b - bin.
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow in
//   diff out 1  difference bit
//   bout out 1  borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they are equal and a borrow comes in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial WIDTH-bit subtractor. One full_subtractor cell is reused for
// WIDTH cycles, LSB first, with the inter-bit borrow held in a flop.
// Operands arrive and results leave over valid/ready handshakes.
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   in_valid  in   1      operand pair valid
//   in_ready  out  1      operands can be accepted (IDLE only)
//   a         in   WIDTH  minuend
//   b         in   WIDTH  subtrahend
//   bin       in   1      initial borrow-in
//   out_valid out  1      result valid (registered)
//   out_ready in   1      sink accepts result
//   diff      out  WIDTH  a - b - bin mod 2^WIDTH (registered)
//   bout      out  1      final borrow-out (registered)
//   zero      out  1      diff == 0 (registered)
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int              CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             cell_a;
    logic             cell_b;
    logic             cell_bin;
    logic             cell_diff;
    logic             cell_bout;

    logic             accept;
    logic             last_bit;
    logic             release_result;

    assign cell_a   = a_sr[0];
    assign cell_b   = b_sr[0];
    assign cell_bin = brw;

    full_subtractor u_cell (
        .a    (cell_a),
        .b    (cell_b),
        .bin  (cell_bin),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Result register with this cycle's difference bit entering at the MSB;
    // after WIDTH shifts the LSB-first bits line up in natural order.
    assign res_next = {cell_diff, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        in_ready       = 1'b0;
        accept         = 1'b0;
        last_bit       = 1'b0;
        release_result = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                last_bit = (cnt == LAST);
                if (last_bit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                release_result = out_ready;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, borrow flop, counter and result registers.
    // diff/bout/zero are only written on the final bit, so they stay put
    // through DONE and after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                brw  <= bin;
                cnt  <= '0;
            end
            if (state == SHIFT) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                res_sr <= res_next;
                brw    <= cell_bout;
                cnt    <= cnt + CW'(1);
                if (last_bit) begin
                    diff      <= res_next;
                    bout      <= cell_bout;
                    zero      <= (res_next == '0);
                    out_valid <= 1'b1;
                end
            end
            if (release_result) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
